if_prefetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined CPU. It replaces the single-register IF + IF_ID pair with a PC generator, a memory request/ready handshake, and a DEPTH-entry prefetch queue. The queue decouples instruction-memory latency from ID stalls. Branch/jump redirects from later stages flush all buffered instructions and restart fetch at the target.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/if_prefetch_stage.sv | 82 ++++++++
 tb/tb_if_prefetch_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch path.
package cpu_pkg;

   localparam int          CPU_XLEN = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam int          PC_STEP  = 4;

   typedef struct packed {
      logic [CPU_XLEN-1:0] pc;
      logic [CPU_XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue: DEPTH slots with flush, push, pop, count and a
// combinational head view so a pushed entry is presentable the next cycle.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  entry_t                       push_entry,
   input  logic                         pop,
   output entry_t                       head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          do_push, do_pop;
   entry_t        slot_q [DEPTH];

   assign do_pop  = pop && (count_reg != '0);
   assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

   // One register per slot so each slot has a single writer.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      entry_t slot_reg;
      always_ff @(posedge clk) begin
         if (do_push && !flush && (wr_ptr_reg == AW'(gi)))
            slot_reg <= push_entry;
      end
      assign slot_q[gi] = slot_reg;
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      if (flush) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end else begin
         if (do_push) wr_ptr_next = wr_ptr_reg + AW'(1);
         if (do_pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign head  = slot_q[rd_ptr_reg];
   assign count = count_reg;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: PC generator, memory request/ready handshake and a
// prefetch queue feeding ID; redirects flush the queue and restart fetch.
module if_prefetch_stage
   import cpu_pkg::*;
#(
   parameter int              XLEN     = CPU_XLEN,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        imem_req,
   output logic [XLEN-1:0]             imem_addr,
   input  logic                        imem_ready,
   input  logic [XLEN-1:0]             imem_data,
   input  logic                        redirect,
   input  logic [XLEN-1:0]             redirect_pc,
   input  logic                        id_ready,
   output logic                        id_valid,
   output logic [XLEN-1:0]             id_inst,
   output logic [XLEN-1:0]             id_pc,
   output logic [XLEN-1:0]             id_pc_4,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

   localparam int CW = $clog2(DEPTH+1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } stage_entry_t;

   logic [XLEN-1:0] fetch_pc_reg;
   logic [CW-1:0]   count;
   logic            transfer;
   logic            pop;
   stage_entry_t    push_entry;
   stage_entry_t    head;
   logic            unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Occupancy only grows on a transfer, so a raised request holds until accepted.
   assign imem_req  = !reset && !redirect && (count < CW'(DEPTH));
   assign imem_addr = fetch_pc_reg;
   assign transfer  = imem_req && imem_ready;
   assign id_valid  = (count != '0);
   assign pop       = id_valid && id_ready;

   assign push_entry.pc   = fetch_pc_reg;
   assign push_entry.inst = imem_data;

   always_ff @(posedge clk) begin
      if (reset)
         fetch_pc_reg <= RESET_PC;
      else if (redirect)
         fetch_pc_reg <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (transfer)
         fetch_pc_reg <= fetch_pc_reg + XLEN'(PC_STEP);
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (stage_entry_t)
   ) u_fetch_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush      (redirect),
      .push       (transfer),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (count)
   );

   // An empty queue presents a NOP with zero PCs rather than stale slot data.
   assign id_inst   = id_valid ? head.inst : XLEN'(NOP_INST);
   assign id_pc     = id_valid ? head.pc : '0;
   assign id_pc_4   = id_valid ? (head.pc + XLEN'(PC_STEP)) : '0;
   assign occupancy = count;

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: two instances (RESET_PC 0 and FFFF_FFF8) in
// lockstep against a list-based model, plus directed literal checkpoints.
module tb_if_prefetch_stage;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC0  = 32'h0000_0000;
   localparam logic [31:0] RPC1  = 32'hFFFF_FFF8;
   localparam logic [31:0] PAT   = 32'hA5A5_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, redirect, imem_ready, id_ready;
   logic [31:0] redirect_pc;
   logic [31:0] data_i [2];

   logic [1:0]  req_o, valid_o;
   logic [31:0] addr_o [2];
   logic [31:0] inst_o [2];
   logic [31:0] pc_o   [2];
   logic [31:0] pc4_o  [2];
   logic [2:0]  occ_o  [2];

   if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC0)) dut0 (
      .clk(clk), .reset(reset), .imem_req(req_o[0]), .imem_addr(addr_o[0]),
      .imem_ready(imem_ready), .imem_data(data_i[0]), .redirect(redirect),
      .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(valid_o[0]),
      .id_inst(inst_o[0]), .id_pc(pc_o[0]), .id_pc_4(pc4_o[0]), .occupancy(occ_o[0])
   );

   if_prefetch_stage #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(RPC1)) dut1 (
      .clk(clk), .reset(reset), .imem_req(req_o[1]), .imem_addr(addr_o[1]),
      .imem_ready(imem_ready), .imem_data(data_i[1]), .redirect(redirect),
      .redirect_pc(redirect_pc), .id_ready(id_ready), .id_valid(valid_o[1]),
      .id_inst(inst_o[1]), .id_pc(pc_o[1]), .id_pc_4(pc4_o[1]), .occupancy(occ_o[1])
   );

   // Model: per instance, next fetch address and an ordered list of {pc, inst}.
   logic [31:0] m_fpc  [2];
   int          m_cnt  [2];
   logic [31:0] m_pc   [2][DEPTH];
   logic [31:0] m_inst [2][DEPTH];
   bit          armed   = 1'b0;
   bit          verbose = 1'b0;

   int errors = 0;
   int checks = 0;

   task automatic chk(string name, int u, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL u%0d %s got=%h exp=%h", u, name, got, exp);
      end
   endtask

   task automatic lit(string name, int u, logic [31:0] got, logic [31:0] exp);
      chk({"lit_", name}, u, got, exp);
   endtask

   task automatic check_all();
      logic        exp_req;
      logic [31:0] hpc;
      if (!armed) return;
      for (int u = 0; u < 2; u++) begin
         exp_req = !reset && !redirect && (m_cnt[u] < DEPTH);
         hpc     = (m_cnt[u] != 0) ? m_pc[u][0] : 32'h0;
         chk("imem_req",  u, {31'b0, req_o[u]},   {31'b0, exp_req});
         chk("imem_addr", u, addr_o[u],           m_fpc[u]);
         chk("id_valid",  u, {31'b0, valid_o[u]}, (m_cnt[u] != 0) ? 32'd1 : 32'd0);
         chk("id_inst",   u, inst_o[u],           (m_cnt[u] != 0) ? m_inst[u][0] : 32'h0);
         chk("id_pc",     u, pc_o[u],             hpc);
         chk("id_pc_4",   u, pc4_o[u],            (m_cnt[u] != 0) ? hpc + 32'd4 : 32'h0);
         chk("occupancy", u, {29'b0, occ_o[u]},   m_cnt[u]);
      end
   endtask

   task automatic model_advance();
      bit can_req, do_pop, do_push;
      for (int u = 0; u < 2; u++) begin
         if (reset) begin
            m_cnt[u] = 0;
            m_fpc[u] = (u == 0) ? RPC0 : RPC1;
         end else if (redirect) begin
            m_cnt[u] = 0;
            m_fpc[u] = redirect_pc & ~32'h3;
         end else begin
            can_req = (m_cnt[u] < DEPTH);
            do_pop  = (m_cnt[u] > 0) && id_ready;
            do_push = can_req && imem_ready;
            if (do_pop) begin
               if (verbose && u == 0)
                  $display("deliver u0 pc=%h inst=%h", m_pc[u][0], m_inst[u][0]);
               for (int i = 0; i < DEPTH - 1; i++) begin
                  m_pc[u][i]   = m_pc[u][i+1];
                  m_inst[u][i] = m_inst[u][i+1];
               end
               m_cnt[u]--;
            end
            if (do_push) begin
               m_pc[u][m_cnt[u]]   = m_fpc[u];
               m_inst[u][m_cnt[u]] = data_i[u];
               m_cnt[u]++;
               m_fpc[u] = m_fpc[u] + 32'd4;
            end
         end
      end
      armed = 1'b1;
   endtask

   // One cycle: drive data, check at mid-cycle, advance model, cross the edge.
   task automatic step(bit pat);
      for (int u = 0; u < 2; u++)
         data_i[u] = pat ? (m_fpc[u] ^ PAT) : $urandom;
      #2;
      check_all();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(int n);
      reset = 1'b1; redirect = 1'b0; imem_ready = 1'b0; id_ready = 1'b0;
      repeat (n) step(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; imem_ready = 1'b0; id_ready = 1'b0;
      redirect_pc = 32'h0; data_i[0] = 32'h0; data_i[1] = 32'h0;
      m_fpc[0] = RPC0; m_fpc[1] = RPC1; m_cnt[0] = 0; m_cnt[1] = 0;
      @(posedge clk); #1;

      // Free-running stream from RESET_PC 0.
      verbose = 1'b1;
      do_reset(2);
      imem_ready = 1'b1; id_ready = 1'b1;
      #1;
      lit("A_req", 0, {31'b0, req_o[0]}, 32'd1);
      lit("A_addr", 0, addr_o[0], 32'h0);
      lit("A_valid", 0, {31'b0, valid_o[0]}, 32'd0);
      step(1'b1);
      for (int k = 0; k < 4; k++) begin
         #1;
         lit("A_pc", 0, pc_o[0], 32'(4 * k));
         lit("A_pc4", 0, pc4_o[0], 32'(4 * k + 4));
         lit("A_inst", 0, inst_o[0], 32'(4 * k) ^ PAT);
         lit("A_occ", 0, {29'b0, occ_o[0]}, 32'd1);
         step(1'b1);
      end

      // Fill to full with ID stalled, then one pop.
      do_reset(1);
      imem_ready = 1'b1; id_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         lit("B_occ", 0, {29'b0, occ_o[0]}, 32'(k));
         step(1'b1);
      end
      #1;
      lit("B_full_occ", 0, {29'b0, occ_o[0]}, 32'd4);
      lit("B_full_req", 0, {31'b0, req_o[0]}, 32'd0);
      lit("B_full_addr", 0, addr_o[0], 32'd16);
      step(1'b1);
      id_ready = 1'b1;
      #1;
      lit("B_pop_pc", 0, pc_o[0], 32'h0);
      lit("B_pop_req", 0, {31'b0, req_o[0]}, 32'd0);
      step(1'b1);
      id_ready = 1'b0;
      #1;
      lit("B_rereq", 0, {31'b0, req_o[0]}, 32'd1);
      lit("B_readdr", 0, addr_o[0], 32'd16);
      lit("B_occ3", 0, {29'b0, occ_o[0]}, 32'd3);
      step(1'b1);

      // Memory not ready: request held with a stable address.
      do_reset(1);
      imem_ready = 1'b0; id_ready = 1'b1;
      repeat (5) begin
         #1;
         lit("C_req", 0, {31'b0, req_o[0]}, 32'd1);
         lit("C_addr", 0, addr_o[0], 32'h0);
         lit("C_valid", 0, {31'b0, valid_o[0]}, 32'd0);
         step(1'b0);
      end

      // Redirect with pcs 0,4,8 queued.
      do_reset(1);
      imem_ready = 1'b1; id_ready = 1'b0;
      repeat (3) step(1'b1);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      #1;
      lit("D_occ", 0, {29'b0, occ_o[0]}, 32'd3);
      lit("D_req", 0, {31'b0, req_o[0]}, 32'd0);
      step(1'b1);
      redirect = 1'b0; imem_ready = 1'b0;
      #1;
      lit("D_flush_occ", 0, {29'b0, occ_o[0]}, 32'd0);
      lit("D_flush_valid", 0, {31'b0, valid_o[0]}, 32'd0);
      lit("D_target", 0, addr_o[0], 32'h100);
      step(1'b1);
      imem_ready = 1'b1;
      step(1'b1);
      imem_ready = 1'b0;
      #1;
      lit("D_new_pc", 0, pc_o[0], 32'h100);
      step(1'b1);

      // Redirect together with pop and memory ready.
      imem_ready = 1'b1; id_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
      step(1'b1);
      redirect = 1'b0; imem_ready = 1'b0;
      #1;
      lit("E_occ", 0, {29'b0, occ_o[0]}, 32'd0);
      lit("E_addr", 0, addr_o[0], 32'h200);
      step(1'b1);

      // Address wrap on the FFFF_FFF8 instance, then mid-stream reset.
      do_reset(1);
      imem_ready = 1'b1; id_ready = 1'b1;
      step(1'b1);
      #1; lit("F_pc0", 1, pc_o[1], 32'hFFFF_FFF8); step(1'b1);
      #1; lit("F_pc1", 1, pc_o[1], 32'hFFFF_FFFC);
      lit("F_pc1_4", 1, pc4_o[1], 32'h0); step(1'b1);
      #1; lit("F_pc2", 1, pc_o[1], 32'h0); step(1'b1);
      reset = 1'b1;
      step(1'b1);
      #1;
      lit("F_rst_valid", 1, {31'b0, valid_o[1]}, 32'd0);
      lit("F_rst_inst", 1, inst_o[1], 32'h0);
      lit("F_rst_pc", 1, pc_o[1], 32'h0);
      lit("F_rst_pc4", 1, pc4_o[1], 32'h0);
      lit("F_rst_occ", 1, {29'b0, occ_o[1]}, 32'd0);
      lit("F_rst_addr", 1, addr_o[1], 32'hFFFF_FFF8);
      lit("F_rst_req", 1, {31'b0, req_o[1]}, 32'd0);
      reset = 1'b0;
      #1;
      lit("F_rel_req", 1, {31'b0, req_o[1]}, 32'd1);
      step(1'b1);
      verbose = 1'b0;

      // Randomised traffic with varying back-pressure.
      for (int blk = 0; blk < 8; blk++) begin
         int rdy_pct, id_pct;
         rdy_pct = $urandom_range(10, 100);
         id_pct  = $urandom_range(5, 100);
         for (int c = 0; c < 500; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            imem_ready  = ($urandom_range(1, 100) <= rdy_pct);
            id_ready    = ($urandom_range(1, 100) <= id_pct);
            step(1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
